stress_trend: RTL and testbench
===============================

# stress_trend

Parametrised successor to the two-channel stress-delta detector. Takes N physiological sample channels (cry volume, heart rate, …), quantises each to its top bits and classifies the per-sample trend as up, down or flat. A state machine requires a configurable run of consecutive "calming" samples before asserting a registered `stress_low`. Sits between the sensor front-end samplers and the rocking-motor controller, which uses `stress_low` to back off.

## Interface
- `CHANNELS`, default 2: number of sample channels.
- `WIDTH`, default 8: raw sample width per channel.
- `QBITS`, default 3: quantised level width; the top `QBITS` bits of each sample, 1 ≤ QBITS ≤ WIDTH.
- `HOLD`, default 4: consecutive calming samples required to enter CALM, ≥ 1.
- `clk` input 1: single clock; all state on rising edge.
- `r` input 1: asynchronous active-low reset.
- `sample` input CHANNELS*WIDTH: channel i at bits [i*WIDTH +: WIDTH].
- `sample_valid` input 1: `sample` is consumed only on cycles where this is high.
- `level` output CHANNELS*QBITS: registered quantised level of the last accepted sample per channel.
- `trend` output CHANNELS*2: registered per-channel trend: 00 flat, 01 down, 10 up; 11 never driven.
- `trend_valid` output 1: one-cycle pulse, `level`/`trend` updated this cycle.
- `stress_low` output 1: registered, high while FSM is in CALM; never combined with `clk`.
- `calm_count` output $clog2(HOLD+1): current run length, saturating at HOLD.

## Operation
- Quantisation: q_i = sample_i[WIDTH-1 -: QBITS]; unsigned compare against the stored history h_i.
- Per-channel trend: down if q_i < h_i, up if q_i > h_i, else flat (see Configuration).
- Sample classes: RISE if any channel up; CALMING if no channel up and at least one down; STEADY if all flat.
- FSM states:
  - INIT: no sample accepted since reset. The first valid sample loads h_i and `level`, and sets `trend` to flat with `trend_valid` = 1. Next state is TRACK.
  - TRACK: on CALMING, count = 1 and go to SETTLE, or go directly to CALM if HOLD = 1. RISE or STEADY stays in TRACK with count = 0.
  - SETTLE: CALMING increments count, and on reaching HOLD goes to CALM. STEADY holds count and state. RISE clears count and goes to TRACK.
  - CALM: RISE clears count and goes to TRACK. CALMING and STEADY stay in CALM with count held at HOLD.
- History h_i updates on every accepted sample, in every state.
- No state, history, or output changes on cycles with `sample_valid` low, except `trend_valid`, which drops to 0.
- Reset values: `level` = 0, `trend` = 00, `trend_valid` = 0, `stress_low` = 0, `calm_count` = 0, h_i = 0, state INIT.
- Reset asserted mid-run returns to INIT immediately, asynchronously. The first sample after reset never produces a down or up trend.

## Timing
- Latency 1: sample accepted at edge k, so `level`, `trend`, `trend_valid`, `calm_count` and `stress_low` reflect it after edge k.
- `stress_low` rises in the cycle after the HOLD-th CALMING sample. It falls in the cycle after the first RISE sample.
- Back-to-back `sample_valid` is supported every cycle. There is no backpressure.
- Reset deassertion is synchronised externally. The block requires `r` to be released at least one cycle before the first `sample_valid`.

## Configuration
- Macro: `STRESS_TREND_HYST_EN`.
- When defined, each channel has a one-step dead band: |q_i − h_i| ≤ 1 is flat. Down requires h_i − q_i ≥ 2 and up requires q_i − h_i ≥ 2. History h_i still updates to q_i on every accepted sample.
- When undefined, any difference of one step or more classifies as down or up, as described in Operation.

## Structure
- Package `stress_pkg`:
  - trend encoding constants TREND_FLAT/TREND_DOWN/TREND_UP (2-bit);
  - FSM state typedef {INIT, TRACK, SETTLE, CALM};
  - sample-class typedef {STEADY, CALMING, RISE}.
- Sub-module `stress_chan`, instantiated CHANNELS times in a generate loop. It contains the quantiser, the history register, the comparator including the dead band, and the registered `level`/`trend` for one channel.
- The top level contains the class reduction across channels, the FSM, the run counter and the outputs.

## Test plan
- Reset then first sample ch0=0xE0, ch1=0x60 → `trend` = flat/flat, `level` = 7/3, `stress_low` = 0, state TRACK.
- HOLD=4: ch0 stepping 0xE0→0xC0→0xA0→0x80→0x60 with ch1 constant → `calm_count` 1,2,3,4, and `stress_low` rises the cycle after the fourth step.
- In CALM, ch1 goes 0x60→0x80 → `trend` ch1 = up, `stress_low` = 0 and `calm_count` = 0 the next cycle.
- In SETTLE at count 2, a STEADY sample followed by idle cycles with `sample_valid` low → count stays 2, and `trend_valid` pulses only on the valid cycle.
- Assert `r` low for one cycle while in CALM → all outputs zero immediately. The next sample is treated as first (flat).
- With `STRESS_TREND_HYST_EN`: ch0 goes 0x80→0x60 (one step) → flat, then 0x60→0x20 (two steps) → down, and `calm_count` = 1.

Source files
------------

// File: rtl/stress_pkg.sv
// Shared encodings for the stress trend detector: trend codes, FSM states
// and the per-sample class derived from all channel trends.
package stress_pkg;

   localparam logic [1:0] TREND_FLAT = 2'b00;
   localparam logic [1:0] TREND_DOWN = 2'b01;
   localparam logic [1:0] TREND_UP   = 2'b10;

   typedef enum logic [1:0] {
      INIT,
      TRACK,
      SETTLE,
      CALM
   } state_e;

   typedef enum logic [1:0] {
      STEADY,
      CALMING,
      RISE
   } class_e;

   // Any rising channel dominates; otherwise any falling channel means calming.
   function automatic class_e classify(input logic any_up, input logic any_down);
      if (any_up) begin
         return RISE;
      end else if (any_down) begin
         return CALMING;
      end
      return STEADY;
   endfunction

endpackage

// File: rtl/stress_chan.sv
// One sample channel: quantiser, history register and trend comparator.
// The history register doubles as the registered level output, since both
// hold the quantised value of the last accepted sample.
// Optional macro STRESS_TREND_HYST_EN adds a one-step dead band to the compare.
module stress_chan
   import stress_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int QBITS = 3
) (
   input  logic             clk,
   input  logic             r,
   input  logic [WIDTH-1:0] sample_i,
   input  logic             accept_i,
   input  logic             first_i,
   output logic [1:0]       trend_now_o,
   output logic [QBITS-1:0] level_o,
   output logic [1:0]       trend_o
);

   logic [QBITS-1:0] q;
   logic [QBITS-1:0] h_q;
   logic [1:0]       trend_q;

   assign q = sample_i[WIDTH-1 -: QBITS];

   generate
      if (QBITS < WIDTH) begin : g_low_bits
         logic unused_low;
         assign unused_low = ^sample_i[WIDTH-QBITS-1:0];
      end
   endgenerate

`ifdef STRESS_TREND_HYST_EN
   localparam logic [QBITS:0] ONE = (QBITS+1)'(1);
   logic [QBITS:0] qx;
   logic [QBITS:0] hx;
   assign qx = {1'b0, q};
   assign hx = {1'b0, h_q};

   // Dead band: only a difference of two or more steps counts as movement.
   always_comb begin
      trend_now_o = TREND_FLAT;
      if (!first_i) begin
         if (qx > hx + ONE) begin
            trend_now_o = TREND_UP;
         end else if (hx > qx + ONE) begin
            trend_now_o = TREND_DOWN;
         end
      end
   end
`else
   // Any one-step difference from history counts as movement.
   always_comb begin
      trend_now_o = TREND_FLAT;
      if (!first_i) begin
         if (q > h_q) begin
            trend_now_o = TREND_UP;
         end else if (q < h_q) begin
            trend_now_o = TREND_DOWN;
         end
      end
   end
`endif

   // History and registered trend follow every accepted sample.
   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         h_q     <= '0;
         trend_q <= TREND_FLAT;
      end else if (accept_i) begin
         h_q     <= q;
         trend_q <= trend_now_o;
      end
   end

   assign level_o = h_q;
   assign trend_o = trend_q;

endmodule

// File: rtl/stress_trend.sv
// N-channel stress trend detector. Channels report up/down/flat; the sample
// class drives a run-length FSM that raises stress_low after HOLD
// consecutive calming samples and drops it on the first rising sample.
// Optional macro STRESS_TREND_HYST_EN enables the per-channel dead band.
//
// state  | meaning
// INIT   | no sample accepted since reset; next sample only seeds history
// TRACK  | tracking, no calming run in progress (count 0)
// SETTLE | calming run in progress, count in 1..HOLD-1
// CALM   | run reached HOLD; stress_low asserted
module stress_trend
   import stress_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int WIDTH    = 8,
   parameter int QBITS    = 3,
   parameter int HOLD     = 4
) (
   input  logic                        clk,
   input  logic                        r,
   input  logic [CHANNELS*WIDTH-1:0]   sample,
   input  logic                        sample_valid,
   output logic [CHANNELS*QBITS-1:0]   level,
   output logic [CHANNELS*2-1:0]       trend,
   output logic                        trend_valid,
   output logic                        stress_low,
   output logic [$clog2(HOLD+1)-1:0]   calm_count
);

   localparam int              CW     = $clog2(HOLD+1);
   localparam logic [CW-1:0]   HOLD_C = CW'(HOLD);

   state_e                state_q, state_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  stress_q;
   logic                  tvalid_q;
   logic [CHANNELS*2-1:0] trend_now;
   logic                  any_up;
   logic                  any_down;
   class_e                cls;
   logic                  first;

   assign first = (state_q == INIT);

   generate
      for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
         stress_chan #(
            .WIDTH (WIDTH),
            .QBITS (QBITS)
         ) u_chan (
            .clk         (clk),
            .r           (r),
            .sample_i    (sample[g*WIDTH +: WIDTH]),
            .accept_i    (sample_valid),
            .first_i     (first),
            .trend_now_o (trend_now[g*2 +: 2]),
            .level_o     (level[g*QBITS +: QBITS]),
            .trend_o     (trend[g*2 +: 2])
         );
      end
   endgenerate

   // Reduce per-channel trends of the incoming sample into one class.
   always_comb begin
      any_up   = 1'b0;
      any_down = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (trend_now[i*2 +: 2] == TREND_UP) begin
            any_up = 1'b1;
         end
         if (trend_now[i*2 +: 2] == TREND_DOWN) begin
            any_down = 1'b1;
         end
      end
      cls = classify(any_up, any_down);
   end

   // Next state and run counter; nothing moves without an accepted sample.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (sample_valid) begin
         case (state_q)
            INIT: begin
               state_d = TRACK;
               count_d = '0;
            end
            TRACK: begin
               if (cls == CALMING) begin
                  count_d = CW'(1);
                  state_d = (HOLD == 1) ? CALM : SETTLE;
               end else begin
                  count_d = '0;
               end
            end
            SETTLE: begin
               if (cls == CALMING) begin
                  count_d = count_q + 1'b1;
                  if (count_d == HOLD_C) begin
                     state_d = CALM;
                  end
               end else if (cls == RISE) begin
                  count_d = '0;
                  state_d = TRACK;
               end
            end
            CALM: begin
               if (cls == RISE) begin
                  count_d = '0;
                  state_d = TRACK;
               end else begin
                  count_d = HOLD_C;
               end
            end
            default: begin
               state_d = INIT;
               count_d = '0;
            end
         endcase
      end
   end

   // State, counter and the registered flags.
   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         state_q  <= INIT;
         count_q  <= '0;
         stress_q <= 1'b0;
         tvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         stress_q <= (state_d == CALM);
         tvalid_q <= sample_valid;
      end
   end

   assign trend_valid = tvalid_q;
   assign stress_low  = stress_q;
   assign calm_count  = count_q;

endmodule

// File: tb/tb_stress_trend.sv
module tb_stress_trend;

   localparam int CH   = 2;
   localparam int W    = 8;
   localparam int QB   = 3;
   localparam int HOLD = 4;
`ifdef STRESS_TREND_HYST_EN
   localparam int THR = 2;
`else
   localparam int THR = 1;
`endif

   logic          clk = 1'b0;
   logic          r = 1'b1;
   logic [15:0]   sample = '0;
   logic          sample_valid = 1'b0;
   logic [5:0]    level;
   logic [3:0]    trend;
   logic          trend_valid;
   logic          stress_low;
   logic [2:0]    calm_count;

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;

   stress_trend #(
      .CHANNELS (CH),
      .WIDTH    (W),
      .QBITS    (QB),
      .HOLD     (HOLD)
   ) dut (
      .clk          (clk),
      .r            (r),
      .sample       (sample),
      .sample_valid (sample_valid),
      .level        (level),
      .trend        (trend),
      .trend_valid  (trend_valid),
      .stress_low   (stress_low),
      .calm_count   (calm_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: quantised history per channel, a calming run length
   // saturating at HOLD, and stress_low whenever the run is full.
   logic [5:0] m_level;
   logic [3:0] m_trend;
   logic       m_tv;
   int         m_cnt;
   bit         m_seen;

   function automatic int qof(input logic [15:0] s, input int ch);
      return int'(s[ch*W + (W-QB) +: QB]);
   endfunction

   function automatic logic [5:0] levels(input logic [15:0] s);
      logic [5:0] l;
      l = '0;
      for (int ch = 0; ch < CH; ch++) l[ch*QB +: QB] = QB'(qof(s, ch));
      return l;
   endfunction

   function automatic logic [3:0] trends(input logic [15:0] s, input logic [5:0] h, input bit seen);
      logic [3:0] t;
      t = '0;
      if (seen) begin
         for (int ch = 0; ch < CH; ch++) begin
            int q, hv;
            q  = qof(s, ch);
            hv = int'(h[ch*QB +: QB]);
            if (q - hv >= THR)      t[ch*2 +: 2] = 2'b10;
            else if (hv - q >= THR) t[ch*2 +: 2] = 2'b01;
         end
      end
      return t;
   endfunction

   function automatic int next_cnt(input int c, input logic [3:0] t, input bit seen);
      if (!seen) return 0;
      if (t[1] || t[3]) return 0;
      if (t[0] || t[2]) return (c + 1 > HOLD) ? HOLD : c + 1;
      return c;
   endfunction

   always @(posedge clk or negedge r) begin
      if (!r) begin
         m_level <= '0;
         m_trend <= '0;
         m_tv    <= 1'b0;
         m_cnt   <= 0;
         m_seen  <= 1'b0;
      end else begin
         m_tv <= sample_valid;
         if (sample_valid) begin
            m_level <= levels(sample);
            m_trend <= trends(sample, m_level, m_seen);
            m_cnt   <= next_cnt(m_cnt, trends(sample, m_level, m_seen), m_seen);
            m_seen  <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("level",       32'(level),       32'(m_level));
         chk("trend",       32'(trend),       32'(m_trend));
         chk("trend_valid", 32'(trend_valid), 32'(m_tv));
         chk("calm_count",  32'(calm_count),  32'(m_cnt));
         chk("stress_low",  32'(stress_low),  32'(m_cnt == HOLD));
      end
   end

   task automatic drv(input logic [7:0] a0, input logic [7:0] a1, input logic v);
      sample       = {a1, a0};
      sample_valid = v;
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic [7:0] a0;
      logic [7:0] a1;
      logic       v;
   } vec_t;

   vec_t tail [14] = '{
      '{8'hA0, 8'h20, 1'b1}, '{8'hA0, 8'h20, 1'b1}, '{8'h40, 8'hC0, 1'b1},
      '{8'h40, 8'hA0, 1'b1}, '{8'h40, 8'hA0, 1'b0}, '{8'h20, 8'h80, 1'b1},
      '{8'h00, 8'h60, 1'b1}, '{8'h00, 8'h40, 1'b1}, '{8'h00, 8'h20, 1'b0},
      '{8'h00, 8'h20, 1'b1}, '{8'h1F, 8'h1F, 1'b1}, '{8'hFF, 8'h00, 1'b1},
      '{8'hFF, 8'hFF, 1'b1}, '{8'h10, 8'h10, 1'b1}
   };

   initial begin
      #1 r = 1'b0;
      #1 cmp_en = 1'b1;
      #20 r = 1'b1;
      @(posedge clk); #1;
      drv(8'h00, 8'h00, 1'b0);

      // First sample only seeds history.
      drv(8'hE0, 8'h60, 1'b1);
      chk("first_level", 32'(level), 32'(6'b011_111));
      chk("first_trend", 32'(trend), 32'(0));
      chk("first_tv",    32'(trend_valid), 32'(1));
      chk("first_stress", 32'(stress_low), 32'(0));

      drv(8'hC0, 8'h60, 1'b1);
`ifndef STRESS_TREND_HYST_EN
      chk("step1_cnt", 32'(calm_count), 32'(1));
      chk("step1_trend", 32'(trend), 32'(4'b0001));
`endif
      drv(8'hA0, 8'h60, 1'b1);
      drv(8'h80, 8'h60, 1'b1);
`ifndef STRESS_TREND_HYST_EN
      chk("step3_cnt", 32'(calm_count), 32'(3));
      chk("step3_stress", 32'(stress_low), 32'(0));
`endif
      drv(8'h60, 8'h60, 1'b1);
`ifndef STRESS_TREND_HYST_EN
      chk("step4_cnt", 32'(calm_count), 32'(4));
      chk("step4_stress", 32'(stress_low), 32'(1));
`endif

      // Rise on ch1 leaves CALM.
      drv(8'h60, 8'h80, 1'b1);
`ifndef STRESS_TREND_HYST_EN
      chk("rise_trend", 32'(trend), 32'(4'b1000));
      chk("rise_stress", 32'(stress_low), 32'(0));
      chk("rise_cnt", 32'(calm_count), 32'(0));
`endif

      // Steady sample and idle cycles inside SETTLE.
      drv(8'h40, 8'h80, 1'b1);
      drv(8'h20, 8'h80, 1'b1);
      drv(8'h20, 8'h80, 1'b1);
`ifndef STRESS_TREND_HYST_EN
      chk("steady_cnt", 32'(calm_count), 32'(2));
`endif
      chk("steady_tv", 32'(trend_valid), 32'(1));
      drv(8'h00, 8'h00, 1'b0);
      chk("idle_tv", 32'(trend_valid), 32'(0));
      drv(8'hFF, 8'hFF, 1'b0);
      drv(8'hFF, 8'hFF, 1'b0);
`ifndef STRESS_TREND_HYST_EN
      chk("idle_cnt", 32'(calm_count), 32'(2));
      chk("idle_level", 32'(level), 32'(6'b100_001));
`endif
      drv(8'h00, 8'h80, 1'b1);
      drv(8'h00, 8'h60, 1'b1);
`ifndef STRESS_TREND_HYST_EN
      chk("calm2_stress", 32'(stress_low), 32'(1));
`endif

      // Asynchronous reset mid-run.
      sample_valid = 1'b0;
      r = 1'b0;
      #1;
      chk("rst_level",  32'(level), 32'(0));
      chk("rst_trend",  32'(trend), 32'(0));
      chk("rst_tv",     32'(trend_valid), 32'(0));
      chk("rst_stress", 32'(stress_low), 32'(0));
      chk("rst_cnt",    32'(calm_count), 32'(0));
      @(posedge clk); #1;
      r = 1'b1;
      drv(8'h00, 8'h00, 1'b0);

      drv(8'h80, 8'hE0, 1'b1);
      chk("refirst_trend", 32'(trend), 32'(0));
      chk("refirst_level", 32'(level), 32'(6'b111_100));
      drv(8'h60, 8'hE0, 1'b1);
`ifdef STRESS_TREND_HYST_EN
      chk("hyst_one_trend", 32'(trend), 32'(0));
      chk("hyst_one_cnt", 32'(calm_count), 32'(0));
`else
      chk("one_step_trend", 32'(trend), 32'(4'b0001));
`endif
      drv(8'h20, 8'hE0, 1'b1);
      chk("two_step_trend", 32'(trend), 32'(4'b0001));
`ifdef STRESS_TREND_HYST_EN
      chk("hyst_two_cnt", 32'(calm_count), 32'(1));
`else
      chk("two_step_cnt", 32'(calm_count), 32'(2));
`endif

      foreach (tail[i]) drv(tail[i].a0, tail[i].a1, tail[i].v);
      drv(8'h00, 8'h00, 1'b0);
      drv(8'h00, 8'h00, 1'b0);

      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
